// File: rtl/fetch_sequencer.sv
// Instruction fetch/sequencing stage: owns the PC, fetches over a req/ack port,
// strobes the control unit once per instruction and applies its branch/halt decision.
module fetch_sequencer #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic              im_req,
  output logic [ADDR_W-1:0] im_addr,
  input  logic              im_ack,
  input  logic [15:0]       im_data,
  output logic [15:0]       IR,
  output logic              CU_en,
  input  logic              bra,
  input  logic [ADDR_W-1:0] BADR,
  input  logic              hlt,
  input  logic              exec_busy,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fetch_err,
  output logic [15:0]       instr_cnt
);

  localparam int unsigned IR_W  = 16;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [IR_W-1:0]    ir_q, ir_d;
  logic               im_req_q, im_req_d;
  logic               cu_en_q, cu_en_d;
  logic               halted_q, halted_d;
  logic               fetch_err_q, fetch_err_d;
  logic [CNT_W-1:0]   instr_cnt_q, instr_cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;

  // Next-state and registered-output logic; tmo_q holds (FETCH cycle number - 1).
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    im_req_d    = im_req_q;
    cu_en_d     = 1'b0;
    halted_d    = halted_q;
    fetch_err_d = fetch_err_q;
    instr_cnt_d = instr_cnt_q;
    tmo_d       = tmo_q;

    case (state_q)
      S_IDLE: begin
        state_d  = S_FETCH;
        im_req_d = 1'b1;
        tmo_d    = '0;
      end
      S_FETCH: begin
        if (im_ack) begin
          ir_d     = im_data;
          im_req_d = 1'b0;
          cu_en_d  = 1'b1;
          state_d  = S_DECODE;
        end else if (tmo_q == TMO_W'(ACK_TIMEOUT - 1)) begin
          fetch_err_d = 1'b1;
          halted_d    = 1'b1;
          im_req_d    = 1'b0;
          state_d     = S_HALT;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (!exec_busy) begin
          instr_cnt_d = instr_cnt_q + CNT_W'(1);
          if (hlt) begin
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            pc_d     = bra ? BADR : pc_q + ADDR_W'(1);
            im_req_d = 1'b1;
            tmo_d    = '0;
            state_d  = S_FETCH;
          end
        end
      end
      S_HALT: begin
        im_req_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= ADDR_W'(RESET_PC);
      ir_q        <= '0;
      im_req_q    <= 1'b0;
      cu_en_q     <= 1'b0;
      halted_q    <= 1'b0;
      fetch_err_q <= 1'b0;
      instr_cnt_q <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      im_req_q    <= im_req_d;
      cu_en_q     <= cu_en_d;
      halted_q    <= halted_d;
      fetch_err_q <= fetch_err_d;
      instr_cnt_q <= instr_cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign im_req    = im_req_q;
  assign im_addr   = pc_q;
  assign IR        = ir_q;
  assign CU_en     = cu_en_q;
  assign pc        = pc_q;
  assign halted    = halted_q;
  assign fetch_err = fetch_err_q;
  assign instr_cnt = instr_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a table of instructions with hand-computed
// addresses/periods, plus hand sequences for halt, timeout and mid-operation reset.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        im_req;
  logic [9:0]  im_addr;
  logic        im_ack;
  logic [15:0] im_data;
  logic [15:0] IR;
  logic        CU_en;
  logic        bra;
  logic [9:0]  BADR;
  logic        hlt;
  logic        exec_busy;
  logic [9:0]  pc;
  logic        halted;
  logic        fetch_err;
  logic [15:0] instr_cnt;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack),
    .im_data(im_data), .IR(IR), .CU_en(CU_en), .bra(bra), .BADR(BADR), .hlt(hlt),
    .exec_busy(exec_busy), .pc(pc), .halted(halted), .fetch_err(fetch_err),
    .instr_cnt(instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction: where it must be fetched from, the memory/CU behaviour for it,
  // and the cycles from its first FETCH cycle to the next fetch (or halt).
  typedef struct {
    logic [9:0]  addr;
    logic [15:0] data;
    int          lat;    // extra wait cycles before ack; -1 = never ack
    int          busy;   // exec_busy cycles
    logic        bra;
    logic [9:0]  badr;
    logic        hlt;
    int          period;
  } rec_t;

  rec_t tbl [8];
  rec_t cur;
  int   checks = 0;
  int   errors = 0;
  int   fetch_cyc = 0;
  int   exec_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: ack on FETCH cycle lat+1 of the current instruction.
  task automatic drive_ack();
    im_ack  = im_req && (fetch_cyc == cur.lat + 1);
    im_data = im_ack ? cur.data : 16'hDEAD;
  endtask

  // Advance one clock, sample 1ns after the edge, then update the memory/CU models.
  task automatic tick();
    @(posedge clk);
    #1;
    if (im_req) fetch_cyc++;
    else        fetch_cyc = 0;
    if (CU_en) begin
      exec_left = cur.busy + 1;
      bra       = cur.bra;
      BADR      = cur.badr;
      hlt       = cur.hlt;
    end else if (exec_left > 0) begin
      exec_left--;
    end
    exec_busy = (exec_left > 0);
    drive_ack();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_pc"},        32'(pc),        32'h0);
    chk({tag, "_ir"},        32'(IR),        32'h0);
    chk({tag, "_im_req"},    32'(im_req),    32'h0);
    chk({tag, "_cu_en"},     32'(CU_en),     32'h0);
    chk({tag, "_halted"},    32'(halted),    32'h0);
    chk({tag, "_fetch_err"}, 32'(fetch_err), 32'h0);
    chk({tag, "_instr_cnt"}, 32'(instr_cnt), 32'h0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    exec_left = 0;
    exec_busy = 1'b0;
    bra = 1'b0;
    hlt = 1'b0;
    BADR = '0;
    tick();
    tick();
    check_reset(tag);
  endtask

  task automatic release_reset(input string tag);
    rst = 1'b0;
    tick();
    chk({tag, "_first_req"},  32'(im_req),  32'h1);
    chk({tag, "_first_addr"}, 32'(im_addr), 32'h0);
  endtask

  // Run one instruction starting at its first FETCH cycle.
  task automatic run_rec(input rec_t r, input int exp_cnt);
    int   n;
    int   cu;
    logic seen_low;
    cur = r;
    drive_ack();
    chk("fetch_addr", 32'(im_addr), 32'(r.addr));
    chk("fetch_req",  32'(im_req),  32'h1);
    n = 0;
    cu = 0;
    seen_low = 1'b0;
    while (n < 40) begin
      tick();
      n++;
      if (CU_en) begin
        cu++;
        chk("ir_load", 32'(IR), 32'(r.data));
      end
      if (!im_req) seen_low = 1'b1;
      else if (!seen_low) chk("addr_hold", 32'(im_addr), 32'(r.addr));
      if ((im_req && seen_low) || halted) break;
    end
    chk("period",       32'(n),         32'(r.period));
    chk("cu_en_pulses", 32'(cu),        32'h1);
    chk("instr_cnt",    32'(instr_cnt), 32'(exp_cnt));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic ok;
    rec_t r;

    tbl[0] = '{10'h000, 16'h1111, 0, 0, 1'b0, 10'h000, 1'b0, 3};
    tbl[1] = '{10'h001, 16'h2222, 0, 0, 1'b0, 10'h000, 1'b0, 3};
    tbl[2] = '{10'h002, 16'h3333, 0, 0, 1'b0, 10'h000, 1'b0, 3};
    tbl[3] = '{10'h003, 16'h4444, 0, 0, 1'b1, 10'h155, 1'b0, 3};
    tbl[4] = '{10'h155, 16'h5555, 3, 5, 1'b0, 10'h000, 1'b0, 11};
    tbl[5] = '{10'h156, 16'h6666, 0, 0, 1'b1, 10'h3FF, 1'b0, 3};
    tbl[6] = '{10'h3FF, 16'h7777, 0, 0, 1'b0, 10'h000, 1'b0, 3};
    tbl[7] = '{10'h000, 16'h8888, 0, 0, 1'b0, 10'h000, 1'b1, 3};

    rst = 1'b1;
    im_ack = 1'b0;
    im_data = '0;
    bra = 1'b0;
    BADR = '0;
    hlt = 1'b0;
    exec_busy = 1'b0;
    cur = tbl[0];

    // Program run: straight line, branch, wait+stall, wrap, halt.
    do_reset("rst0");
    release_reset("rel0");
    for (int i = 0; i < 8; i++) run_rec(tbl[i], i + 1);
    chk("halt_flag", 32'(halted), 32'h1);
    chk("halt_pc",   32'(pc),     32'h0);
    bra = 1'b1;
    BADR = 10'h123;
    hlt = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (im_req || CU_en || !halted || pc != 10'h000 || instr_cnt != 16'd8) ok = 1'b0;
    end
    chk("halt_hold", 32'(ok), 32'h1);

    // Ack in FETCH cycle 15 is accepted; no ack through cycle 15 times out.
    do_reset("rst1");
    cur = '{10'h000, 16'hABCD, 14, 0, 1'b0, 10'h000, 1'b0, 17};
    release_reset("rel1");
    run_rec(cur, 1);
    chk("late_ack_no_err", 32'(fetch_err), 32'h0);
    cur = '{10'h001, 16'hBEEF, -1, 0, 1'b0, 10'h000, 1'b0, 0};
    drive_ack();
    repeat (14) tick();
    chk("tmo_c15_req", 32'(im_req),    32'h1);
    chk("tmo_c15_err", 32'(fetch_err), 32'h0);
    tick();
    chk("tmo_err",    32'(fetch_err), 32'h1);
    chk("tmo_halted", 32'(halted),    32'h1);
    chk("tmo_req",    32'(im_req),    32'h0);
    chk("tmo_pc",     32'(pc),        32'h001);
    chk("tmo_ir",     32'(IR),        32'hABCD);

    // Reset while a fetch is outstanding.
    do_reset("rst2");
    cur = '{10'h000, 16'h1234, -1, 0, 1'b0, 10'h000, 1'b0, 0};
    release_reset("rel2");
    repeat (3) tick();
    chk("midfetch_req", 32'(im_req), 32'h1);
    rst = 1'b1;
    tick();
    check_reset("midfetch");
    exec_left = 0;
    exec_busy = 1'b0;

    // Reset during an exec_busy stall: the instruction must not retire.
    cur = '{10'h000, 16'h4321, 0, 10, 1'b0, 10'h000, 1'b0, 0};
    release_reset("rel3");
    repeat (4) tick();
    chk("midstall_busy", 32'(exec_busy), 32'h1);
    rst = 1'b1;
    tick();
    check_reset("midstall");
    exec_left = 0;
    exec_busy = 1'b0;
    release_reset("rel4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction fetch and sequencing stage directly upstream of the control unit. Holds the program counter, fetches 16-bit instructions over a req/ack instruction-memory port, and loads IR. Pulses CU_en once per instruction, then applies the control unit's registered bra/BADR/hlt to pick the next PC. Owns processor halt and fetch-timeout error state.

## Interface
- ADDR_W, 10: PC / branch address width; matches the 10-bit BADR field.
- RESET_PC, 0: PC value loaded on reset.
- ACK_TIMEOUT, 15: maximum FETCH cycles, including the request cycle, to wait for im_ack.

- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- im_req  out  1  instruction read request
- im_addr  out  ADDR_W  instruction address; equals pc
- im_ack  in  1  read data valid on im_data this cycle
- im_data  in  16  instruction word
- IR  out  16  instruction register, feeds the control unit
- CU_en  out  1  one-cycle decode strobe to the control unit
- bra  in  1  branch-taken from the control unit (registered)
- BADR  in  ADDR_W  branch target from the control unit (registered)
- hlt  in  1  halt request from the control unit (registered)
- exec_busy  in  1  multi-cycle execution in progress (MUL/DIV/FACTRL); stalls sequencing
- pc  out  ADDR_W  program counter
- halted  out  1  sequencer stopped
- fetch_err  out  1  sticky; fetch timed out
- instr_cnt  out  16  retired-instruction count

## Operation
- Reset values: pc=RESET_PC, IR=16'h0000, im_req=0, CU_en=0, halted=0, fetch_err=0, instr_cnt=0, timeout counter=0, state=IDLE.
- IDLE: im_req=0. Leave for FETCH on the first clock with rst=0.
- FETCH
  - im_req=1, im_addr=pc, both held stable until ack.
  - im_ack=1 loads IR<=im_data and moves to DECODE. An ack in the first FETCH cycle is legal.
  - im_ack is ignored whenever im_req=0.
- DECODE: CU_en=1 for exactly this cycle; IR is stable. The control unit latches its outputs at the end of this cycle. Go to EXEC.
- EXEC
  - bra, BADR and hlt are valid throughout.
  - While exec_busy=1, stay in EXEC; pc and IR hold.
  - On the first cycle with exec_busy=0:
    - hlt=1: pc holds, halted<=1, go to HALT.
    - else bra=1: pc<=BADR, go to FETCH.
    - else: pc<=pc+1 modulo 2^ADDR_W (0x3FF wraps to 0x000), go to FETCH.
  - instr_cnt increments by 1, wrapping modulo 2^16, on every EXEC exit, including HLT.
- HALT
  - im_req=0, CU_en=0, halted=1.
  - Only rst leaves this state; bra and hlt are ignored.
- Timeout
  - The counter clears on FETCH entry and increments on each FETCH cycle without ack.
  - If im_ack is still low in FETCH cycle number ACK_TIMEOUT: fetch_err<=1, halted<=1, im_req<=0, go to HALT. pc keeps the faulting address; IR is unchanged.
  - An ack arriving in cycle ACK_TIMEOUT is accepted and is not a timeout.
- Reset mid-operation: rst in any state forces all reset values at that edge, including dropping an outstanding im_req. An instruction in EXEC is not retired. The instruction memory is reset by the same rst.

## Timing
- Minimum instruction period is 3 cycles (FETCH with immediate ack, DECODE, EXEC). Each memory wait cycle adds 1; each exec_busy cycle adds 1.
- CU_en is never high in two consecutive cycles. Consecutive CU_en pulses are at least 3 cycles apart.
- pc and IR change only at FETCH→DECODE (IR) and EXEC exit (pc). im_addr follows pc combinationally.
- The first im_req rises the cycle after rst falls (the IDLE cycle), so the first fetch is 2 cycles after reset release.
- halted rises the cycle after the deciding EXEC or FETCH edge.

## Test plan
- Straight-line run: zero-wait memory, 4 non-branch words at 0x000–0x003, bra=hlt=0 → im_addr 0,1,2,3. CU_en pulses 3 cycles apart. instr_cnt=4 after 12 cycles.
- Branch: bra=1 with BADR=0x155 in EXEC → next im_addr=0x155. No fetch from pc+1 appears.
- Stall plus wait: im_ack delayed 3 cycles and exec_busy high for 5 cycles → instruction period 3+3+5=11 cycles. im_addr stable throughout the wait; CU_en pulses once.
- Halt and wrap: pc=0x3FF with a non-branch word → next fetch at 0x000. HLT at 0x000 → halted=1, pc=0x000, im_req stays 0 for 20 cycles, instr_cnt incremented.
- Timeout boundary, ACK_TIMEOUT=15: ack in FETCH cycle 15 → accepted, fetch_err=0. No ack through cycle 15 → fetch_err=1, halted=1, im_req=0 on cycle 16.
- Reset mid-fetch and mid-stall: rst asserted while im_req=1 (and separately while exec_busy=1) → next cycle all outputs at reset values. First new im_req at RESET_PC 2 cycles after rst release.
